nmc_arb: RTL

NMC_ARB -- requirements
Module: nmc_arb

---
 rtl/nmc_arb.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/nmc_arb.sv
// nmc_arb: host write / multi-requester query arbiter for the nmc.
// Tags track in-flight queries so responses route back to requesters.
package nmc_pkg;
  localparam int NMC_RES_W = 16;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } nmc_wr_req_t;

  typedef struct packed {
    logic [31:0] key;
  } nmc_qr_req_t;

  typedef struct packed {
    logic                 valid;
    logic                 found;
    logic [NMC_RES_W-1:0] result;
  } nmc_qr_resp_t;
endpackage

module nmc_arb
  import nmc_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int MAX_OUT = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  nmc_wr_req_t                  wr_req,
  output logic                         wr_ready,
  input  logic [N_REQ-1:0]             qr_valid,
  input  nmc_qr_req_t                  qr_req [N_REQ],
  output logic [N_REQ-1:0]             qr_ready,
  output logic [N_REQ-1:0]             resp_valid,
  output logic                         resp_found,
  output logic [NMC_RES_W-1:0]         resp_result,
  output nmc_wr_req_t                  nmc_wr_req,
  output logic                         nwr_push,
  input  logic                         nwr_full,
  output nmc_qr_req_t                  nmc_qr_req,
  output logic                         nqr_push,
  input  logic                         nqr_full,
  input  nmc_qr_resp_t                 nmc_qr_resp,
  output logic [$clog2(MAX_OUT):0]     out_cnt,
  output logic                         err
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW = $clog2(MAX_OUT);
  localparam int CW = AW + 1;

  typedef enum logic {RUN, DRAIN} state_t;

  state_t         state;
  logic [IW-1:0]  rr_ptr;
  logic [IW-1:0]  tag_q [MAX_OUT];
  logic [AW-1:0]  wptr;
  logic [AW-1:0]  rptr;
  logic           qr_open;
  logic           gnt;
  logic [IW-1:0]  gidx;
  logic           pop;
  int             idx;

  // Round-robin search from rr_ptr; writes and drain block all grants.
  always_comb begin
    gnt     = 1'b0;
    gidx    = '0;
    idx     = 0;
    qr_open = rst && (state == RUN) && !wr_valid && !nqr_full
              && (out_cnt < CW'(MAX_OUT));
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(rr_ptr) + i) % N_REQ;
      if (qr_open && !gnt && qr_valid[idx]) begin
        gnt  = 1'b1;
        gidx = IW'(idx);
      end
    end
  end

  // Handshake and downstream push wiring.
  always_comb begin
    wr_ready   = rst && (state == RUN) && (out_cnt == '0) && !nwr_full;
    nwr_push   = wr_valid && wr_ready;
    nmc_wr_req = wr_req;
    qr_ready   = '0;
    if (gnt) qr_ready[gidx] = 1'b1;
    nqr_push   = gnt;
    nmc_qr_req = qr_req[gidx];
    pop        = nmc_qr_resp.valid && (out_cnt != '0);
  end

  // Write-ordering FSM: drain in-flight queries before a write goes out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      unique case (state)
        RUN:   if (wr_valid && out_cnt != '0) state <= DRAIN;
        DRAIN: if (out_cnt == '0) state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  // Round-robin pointer moves past the last granted requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (gnt) begin
      rr_ptr <= (gidx == IW'(N_REQ - 1)) ? '0 : gidx + IW'(1);
    end
  end

  // Tag storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge clk) begin
    if (gnt) tag_q[wptr] <= gidx;
  end

  // Tag FIFO pointers and in-flight count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr    <= '0;
      rptr    <= '0;
      out_cnt <= '0;
    end else begin
      if (gnt) wptr <= wptr + AW'(1);
      if (pop) rptr <= rptr + AW'(1);
      unique case (1'b1)
        gnt && !pop: out_cnt <= out_cnt + CW'(1);
        pop && !gnt: out_cnt <= out_cnt - CW'(1);
        default:     out_cnt <= out_cnt;
      endcase
    end
  end

  // Registered response routed to the head tag's requester.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_valid  <= '0;
      resp_found  <= 1'b0;
      resp_result <= '0;
    end else begin
      resp_valid <= '0;
      if (pop) begin
        resp_valid[tag_q[rptr]] <= 1'b1;
        resp_found              <= nmc_qr_resp.found;
        resp_result             <= nmc_qr_resp.result;
      end
    end
  end

  // Sticky flag for a response with no outstanding query.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (nmc_qr_resp.valid && out_cnt == '0) begin
      err <= 1'b1;
    end
  end

endmodule
